// File: rtl/dcache_mon_pkg.sv
// Shared definitions for the data-cache event monitor.
//   ev_type_e  : event code carried on ev_type_o
//   CNT_*      : statistics counter indices used by the readout port
//   ch_state_e : per-channel miss-tracking FSM state
package dcache_mon_pkg;

  typedef enum logic [2:0] {
    EV_RD_HIT     = 3'd0,
    EV_WR_HIT     = 3'd1,
    EV_RD_MISS    = 3'd2,
    EV_WR_MISS    = 3'd3,
    EV_RD_MISS_WB = 3'd4,
    EV_WR_MISS_WB = 3'd5
  } ev_type_e;

  localparam int unsigned CNT_RD_HIT     = 0;
  localparam int unsigned CNT_WR_HIT     = 1;
  localparam int unsigned CNT_RD_MISS    = 2;
  localparam int unsigned CNT_WR_MISS    = 3;
  localparam int unsigned CNT_WRITE_BACK = 4;
  localparam int unsigned CNT_STALL      = 5;
  localparam int unsigned CNT_MAX_LAT    = 6;
  localparam int unsigned NUM_CNT        = 7;

  typedef enum logic {
    ST_IDLE      = 1'b0,
    ST_MISS_WAIT = 1'b1
  } ch_state_e;

  function automatic ev_type_e miss_code(input logic is_wr, input logic dirty);
    case ({dirty, is_wr})
      2'b00:   return EV_RD_MISS;
      2'b01:   return EV_WR_MISS;
      2'b10:   return EV_RD_MISS_WB;
      default: return EV_WR_MISS_WB;
    endcase
  endfunction

endpackage

// File: rtl/dcache_mon_channel.sv
// One monitored cache port: miss-tracking FSM, miss latches, latency
// counter, registered event output and seven saturating statistics counters.
// Ports:
//   clk_i, rst_i (sync, active-low), enable_i, clear_i
//   mem_read_i, mem_write_i, stall_i, ctrl_idle_i, dirty_i, addr_i : cache port view
//   ev_valid_o, ev_type_o, ev_addr_o, ev_lat_o                    : event stream
//   cnt_o                                                           : counter values
module dcache_mon_channel
  import dcache_mon_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned CNT_W  = 32,
  parameter int unsigned LAT_W  = 8
) (
  input  logic                          clk_i,
  input  logic                          rst_i,
  input  logic                          enable_i,
  input  logic                          clear_i,
  input  logic                          mem_read_i,
  input  logic                          mem_write_i,
  input  logic                          stall_i,
  input  logic                          ctrl_idle_i,
  input  logic                          dirty_i,
  input  logic [ADDR_W-1:0]             addr_i,
  output logic                          ev_valid_o,
  output logic [2:0]                    ev_type_o,
  output logic [ADDR_W-1:0]             ev_addr_o,
  output logic [LAT_W-1:0]              ev_lat_o,
  output logic [NUM_CNT-1:0][CNT_W-1:0] cnt_o
);

  localparam int unsigned MW = (LAT_W > CNT_W) ? LAT_W : CNT_W;

  ch_state_e                    state_q, state_d;
  logic                         access, hit, miss_start, miss_done, fire;
  ev_type_e                     ev_type_d;
  logic [ADDR_W-1:0]            ev_addr_d;
  logic [LAT_W-1:0]             ev_lat_d;
  logic                         lt_wr_q, lt_dirty_q;
  logic [ADDR_W-1:0]            lt_addr_q;
  logic [LAT_W-1:0]             lat_q;
  logic [NUM_CNT-1:0][CNT_W-1:0] cnt_q;
  logic [MW-1:0]                lat_ext, max_ext;
  logic [CNT_W-1:0]             max_new;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == '1) ? v : v + CNT_W'(1);
  endfunction

  assign access = mem_read_i | mem_write_i;

  always_ff @(posedge clk_i) begin
    if (!rst_i) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // The FSM tracks misses regardless of enable_i so that a miss spanning
  // a re-enable still completes with the right latency.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:      if (access && stall_i && ctrl_idle_i) state_d = ST_MISS_WAIT;
      ST_MISS_WAIT: if (!stall_i) state_d = ST_IDLE;
      default:      state_d = ST_IDLE;
    endcase
  end

  // Completion cycle of a miss is decoded only as miss_done, never as a hit.
  always_comb begin
    hit        = 1'b0;
    miss_start = 1'b0;
    miss_done  = 1'b0;
    ev_type_d  = EV_RD_HIT;
    ev_addr_d  = addr_i;
    ev_lat_d   = '0;
    case (state_q)
      ST_IDLE: begin
        hit        = access && !stall_i;
        miss_start = access && stall_i && ctrl_idle_i;
        ev_type_d  = mem_write_i ? EV_WR_HIT : EV_RD_HIT;
      end
      ST_MISS_WAIT: begin
        miss_done = !stall_i;
        ev_type_d = miss_code(lt_wr_q, lt_dirty_q);
        ev_addr_d = lt_addr_q;
        ev_lat_d  = lat_q;
      end
      default: ;
    endcase
    fire = enable_i && (hit || miss_done);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      lt_wr_q    <= 1'b0;
      lt_dirty_q <= 1'b0;
      lt_addr_q  <= '0;
      lat_q      <= '0;
    end else if (miss_start) begin
      lt_wr_q    <= mem_write_i;
      lt_dirty_q <= dirty_i;
      lt_addr_q  <= addr_i;
      lat_q      <= LAT_W'(1);
    end else if (state_q == ST_MISS_WAIT && stall_i && lat_q != '1) begin
      lat_q <= lat_q + LAT_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      ev_valid_o <= 1'b0;
      ev_type_o  <= '0;
      ev_addr_o  <= '0;
      ev_lat_o   <= '0;
    end else begin
      ev_valid_o <= fire;
      if (fire) begin
        ev_type_o <= 3'(ev_type_d);
        ev_addr_o <= ev_addr_d;
        ev_lat_o  <= ev_lat_d;
      end
    end
  end

  // Latency is compared in the wider of the two widths; if the counter is
  // narrower than the latency, the recorded maximum saturates.
  assign lat_ext = MW'(lat_q);
  assign max_ext = MW'(cnt_q[CNT_MAX_LAT]);
  assign max_new = (lat_ext > MW'({CNT_W{1'b1}})) ? '1 : CNT_W'(lat_ext);

  always_ff @(posedge clk_i) begin
    if (!rst_i || clear_i) begin
      cnt_q <= '0;
    end else if (enable_i) begin
      if (hit) begin
        if (mem_write_i) cnt_q[CNT_WR_HIT] <= sat_inc(cnt_q[CNT_WR_HIT]);
        else             cnt_q[CNT_RD_HIT] <= sat_inc(cnt_q[CNT_RD_HIT]);
      end
      if (miss_done) begin
        if (lt_wr_q) cnt_q[CNT_WR_MISS] <= sat_inc(cnt_q[CNT_WR_MISS]);
        else         cnt_q[CNT_RD_MISS] <= sat_inc(cnt_q[CNT_RD_MISS]);
        if (lt_dirty_q) cnt_q[CNT_WRITE_BACK] <= sat_inc(cnt_q[CNT_WRITE_BACK]);
        if (lat_ext > max_ext) cnt_q[CNT_MAX_LAT] <= max_new;
      end
      if (stall_i) cnt_q[CNT_STALL] <= sat_inc(cnt_q[CNT_STALL]);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/dcache_event_monitor.sv
// Data-cache event monitor: one dcache_mon_channel per cache port plus a
// registered counter readout.
// Ports:
//   clk_i, rst_i (sync, active-low), enable_i, clear_i
//   mem_read_i/mem_write_i/stall_i/ctrl_idle_i/dirty_i [NUM_CH], addr_i [NUM_CH*ADDR_W]
//   ev_valid_o [NUM_CH], ev_type_o [NUM_CH*3], ev_addr_o, ev_lat_o : per-channel events
//   rd_ch_i, rd_idx_i -> rd_data_o (one cycle later; out-of-range reads 0)
module dcache_event_monitor
  import dcache_mon_pkg::*;
#(
  parameter  int unsigned NUM_CH = 1,
  parameter  int unsigned ADDR_W = 32,
  parameter  int unsigned CNT_W  = 32,
  parameter  int unsigned LAT_W  = 8,
  localparam int unsigned CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     clear_i,
  input  logic [NUM_CH-1:0]        mem_read_i,
  input  logic [NUM_CH-1:0]        mem_write_i,
  input  logic [NUM_CH-1:0]        stall_i,
  input  logic [NUM_CH-1:0]        ctrl_idle_i,
  input  logic [NUM_CH-1:0]        dirty_i,
  input  logic [NUM_CH*ADDR_W-1:0] addr_i,
  output logic [NUM_CH-1:0]        ev_valid_o,
  output logic [NUM_CH*3-1:0]      ev_type_o,
  output logic [NUM_CH*ADDR_W-1:0] ev_addr_o,
  output logic [NUM_CH*LAT_W-1:0]  ev_lat_o,
  input  logic [CH_W-1:0]          rd_ch_i,
  input  logic [2:0]               rd_idx_i,
  output logic [CNT_W-1:0]         rd_data_o
);

  logic [NUM_CNT-1:0][CNT_W-1:0] cnt_all [NUM_CH];
  logic [CNT_W-1:0]              rd_sel;

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    dcache_mon_channel #(
      .ADDR_W(ADDR_W),
      .CNT_W (CNT_W),
      .LAT_W (LAT_W)
    ) u_ch (
      .clk_i      (clk_i),
      .rst_i      (rst_i),
      .enable_i   (enable_i),
      .clear_i    (clear_i),
      .mem_read_i (mem_read_i[c]),
      .mem_write_i(mem_write_i[c]),
      .stall_i    (stall_i[c]),
      .ctrl_idle_i(ctrl_idle_i[c]),
      .dirty_i    (dirty_i[c]),
      .addr_i     (addr_i[c*ADDR_W +: ADDR_W]),
      .ev_valid_o (ev_valid_o[c]),
      .ev_type_o  (ev_type_o[c*3 +: 3]),
      .ev_addr_o  (ev_addr_o[c*ADDR_W +: ADDR_W]),
      .ev_lat_o   (ev_lat_o[c*LAT_W +: LAT_W]),
      .cnt_o      (cnt_all[c])
    );
  end

  // Matching per channel keeps unpopulated rd_ch_i codes reading zero
  // without comparing against a constant that may exceed the select range.
  always_comb begin
    rd_sel = '0;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (rd_ch_i == CH_W'(c) && rd_idx_i < 3'(NUM_CNT)) rd_sel = cnt_all[c][rd_idx_i];
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) rd_data_o <= '0;
    else        rd_data_o <= rd_sel;
  end

endmodule

// File: tb/tb_dcache_event_monitor.sv
// Bench for dcache_event_monitor: two instances (2-channel wide counters,
// 1-channel narrow counters sharing channel 0 stimulus) checked every cycle
// against a cycle-stamped behavioural model, plus directed literal checks.
module tb_dcache_event_monitor;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        en, clr;
  logic [1:0]  rd, wr, st, ci, dt;
  logic [31:0] addr;
  logic        rd_ch;
  logic [2:0]  rd_idx;

  logic [1:0]  a_ev_valid;
  logic [5:0]  a_ev_type;
  logic [31:0] a_ev_addr;
  logic [15:0] a_ev_lat;
  logic [15:0] a_rd_data;
  logic [0:0]  b_ev_valid;
  logic [2:0]  b_ev_type;
  logic [15:0] b_ev_addr;
  logic [2:0]  b_ev_lat;
  logic [3:0]  b_rd_data;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  dcache_event_monitor #(.NUM_CH(2), .ADDR_W(16), .CNT_W(16), .LAT_W(8)) u_dut_a (
    .clk_i(clk), .rst_i(rst_n), .enable_i(en), .clear_i(clr),
    .mem_read_i(rd), .mem_write_i(wr), .stall_i(st), .ctrl_idle_i(ci), .dirty_i(dt),
    .addr_i(addr), .ev_valid_o(a_ev_valid), .ev_type_o(a_ev_type), .ev_addr_o(a_ev_addr),
    .ev_lat_o(a_ev_lat), .rd_ch_i(rd_ch), .rd_idx_i(rd_idx), .rd_data_o(a_rd_data)
  );

  dcache_event_monitor #(.NUM_CH(1), .ADDR_W(16), .CNT_W(4), .LAT_W(3)) u_dut_b (
    .clk_i(clk), .rst_i(rst_n), .enable_i(en), .clear_i(clr),
    .mem_read_i(rd[0:0]), .mem_write_i(wr[0:0]), .stall_i(st[0:0]), .ctrl_idle_i(ci[0:0]),
    .dirty_i(dt[0:0]), .addr_i(addr[15:0]), .ev_valid_o(b_ev_valid), .ev_type_o(b_ev_type),
    .ev_addr_o(b_ev_addr), .ev_lat_o(b_ev_lat), .rd_ch_i(rd_ch), .rd_idx_i(rd_idx),
    .rd_data_o(b_rd_data)
  );

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  // ---------------- behavioural model (index 0 = dut_a, 1 = dut_b) ----------
  int mcnt   [2][2][7];
  int mbusy  [2][2];
  int mstart [2][2];
  int mwr    [2][2];
  int mdirty [2][2];
  int maddr  [2][2];
  int ev_v   [2][2];
  int ev_t   [2][2];
  int ev_a   [2][2];
  int ev_l   [2][2];
  int exp_rd [2];
  int cyc = 0;
  int lat_v;
  int acc_v;

  function automatic int cmax(input int d); return (d == 0) ? 65535 : 15; endfunction
  function automatic int lmax(input int d); return (d == 0) ? 255 : 7; endfunction
  function automatic int nch(input int d);  return (d == 0) ? 2 : 1; endfunction

  task automatic bump(input int d, input int c, input int k);
    if (mcnt[d][c][k] < cmax(d)) mcnt[d][c][k] = mcnt[d][c][k] + 1;
  endtask

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      exp_rd[d] = 0;
      if (rst_n && int'(rd_ch) < nch(d) && int'(rd_idx) < 7)
        exp_rd[d] = mcnt[d][int'(rd_ch)][int'(rd_idx)];
      for (int c = 0; c < nch(d); c++) begin
        ev_v[d][c] = 0;
        if (!rst_n) begin
          mbusy[d][c] = 0;
          for (int k = 0; k < 7; k++) mcnt[d][c][k] = 0;
        end else begin
          acc_v = int'(rd[c] | wr[c]);
          if (mbusy[d][c] == 0) begin
            if (acc_v != 0 && !st[c]) begin
              if (en) begin
                ev_v[d][c] = 1;
                ev_t[d][c] = int'(wr[c]);
                ev_a[d][c] = int'(addr[c*16 +: 16]);
                ev_l[d][c] = 0;
                bump(d, c, int'(wr[c]));
              end
            end else if (acc_v != 0 && st[c] && ci[c]) begin
              mbusy[d][c]  = 1;
              mstart[d][c] = cyc;
              mwr[d][c]    = int'(wr[c]);
              mdirty[d][c] = int'(dt[c]);
              maddr[d][c]  = int'(addr[c*16 +: 16]);
            end
          end else if (!st[c]) begin
            mbusy[d][c] = 0;
            lat_v = cyc - mstart[d][c];
            if (lat_v > lmax(d)) lat_v = lmax(d);
            if (en) begin
              ev_v[d][c] = 1;
              ev_t[d][c] = 2 + mwr[d][c] + 2 * mdirty[d][c];
              ev_a[d][c] = maddr[d][c];
              ev_l[d][c] = lat_v;
              bump(d, c, 2 + mwr[d][c]);
              if (mdirty[d][c] != 0) bump(d, c, 4);
              if (lat_v > mcnt[d][c][6]) mcnt[d][c][6] = lat_v;
            end
          end
          if (en && st[c]) bump(d, c, 5);
          if (clr) for (int k = 0; k < 7; k++) mcnt[d][c][k] = 0;
        end
      end
    end
    cyc++;
  end

  always @(negedge clk) begin
    if (cmp_en) begin
      for (int c = 0; c < 2; c++) begin
        chk("a_ev_valid", longint'(a_ev_valid[c]), longint'(ev_v[0][c]));
        if (ev_v[0][c] != 0) begin
          chk("a_ev_type", longint'(a_ev_type[c*3 +: 3]), longint'(ev_t[0][c]));
          chk("a_ev_addr", longint'(a_ev_addr[c*16 +: 16]), longint'(ev_a[0][c]));
          chk("a_ev_lat", longint'(a_ev_lat[c*8 +: 8]), longint'(ev_l[0][c]));
        end
      end
      chk("b_ev_valid", longint'(b_ev_valid), longint'(ev_v[1][0]));
      if (ev_v[1][0] != 0) begin
        chk("b_ev_type", longint'(b_ev_type), longint'(ev_t[1][0]));
        chk("b_ev_addr", longint'(b_ev_addr), longint'(ev_a[1][0]));
        chk("b_ev_lat", longint'(b_ev_lat), longint'(ev_l[1][0]));
      end
      chk("a_rd_data", longint'(a_rd_data), longint'(exp_rd[0]));
      chk("b_rd_data", longint'(b_rd_data), longint'(exp_rd[1]));
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b1; clr = 1'b0;
    rd = '0; wr = '0; st = '0; ci = '1; dt = '0;
  endtask

  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  task automatic read_cnt(input int ch, input int idx, input longint exp_a,
                          input longint exp_b, input string nm);
    rd_ch  = ch[0];
    rd_idx = idx[2:0];
    step();
    chk({"a_", nm}, longint'(a_rd_data), exp_a);
    chk({"b_", nm}, longint'(b_rd_data), exp_b);
  endtask

  int run [2];

  initial begin
    idle();
    addr = '0; rd_ch = 1'b0; rd_idx = 3'd0;
    do_reset();
    cmp_en = 1'b1;

    // reset state
    chk("reset_ev_valid", longint'(a_ev_valid), 0);
    chk("reset_a_rd", longint'(a_rd_data), 0);
    chk("reset_b_rd", longint'(b_rd_data), 0);

    // read hit
    rd[0] = 1'b1; addr[15:0] = 16'h0020;
    step();
    chk("hit_valid", longint'(a_ev_valid[0]), 1);
    chk("hit_type", longint'(a_ev_type[2:0]), 0);
    chk("hit_addr", longint'(a_ev_addr[15:0]), 32);
    chk("hit_lat", longint'(a_ev_lat[7:0]), 0);
    idle();
    read_cnt(0, 0, 1, 1, "hit_cnt0");

    // dirty write miss, access held through completion
    do_reset();
    wr[0] = 1'b1; st[0] = 1'b1; dt[0] = 1'b1; addr[15:0] = 16'h0400;
    repeat (4) step();
    st[0] = 1'b0;
    step();
    chk("wbmiss_valid", longint'(a_ev_valid[0]), 1);
    chk("wbmiss_type", longint'(a_ev_type[2:0]), 5);
    chk("wbmiss_lat", longint'(a_ev_lat[7:0]), 4);
    chk("wbmiss_addr", longint'(a_ev_addr[15:0]), 1024);
    idle();
    read_cnt(0, 1, 0, 0, "wbmiss_wrhit");
    read_cnt(0, 3, 1, 1, "wbmiss_cnt3");
    read_cnt(0, 4, 1, 1, "wbmiss_cnt4");
    read_cnt(0, 5, 4, 4, "wbmiss_cnt5");
    read_cnt(0, 6, 4, 4, "wbmiss_cnt6");

    // saturation in the narrow instance
    do_reset();
    rd[0] = 1'b1; addr[15:0] = 16'h0100;
    repeat (20) step();
    idle();
    read_cnt(0, 0, 20, 15, "sat_cnt0");
    rd[0] = 1'b1; st[0] = 1'b1;
    repeat (10) step();
    st[0] = 1'b0; rd[0] = 1'b0;
    step();
    chk("sat_b_lat", longint'(b_ev_lat), 7);
    chk("sat_a_lat", longint'(a_ev_lat[7:0]), 10);
    idle();
    read_cnt(0, 6, 10, 7, "sat_cnt6");

    // clear coincident with a hit
    rd[0] = 1'b1; clr = 1'b1;
    step();
    chk("clr_ev_valid", longint'(a_ev_valid[0]), 1);
    idle();
    read_cnt(0, 0, 0, 0, "clr_cnt0");

    // reset during MISS_WAIT
    wr[0] = 1'b1; st[0] = 1'b1;
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1; wr[0] = 1'b0; st[0] = 1'b0;
    step();
    chk("rstmiss_valid", longint'(a_ev_valid[0]), 0);
    for (int k = 0; k < 7; k++) read_cnt(0, k, 0, 0, "rstmiss_cnt");
    rd[0] = 1'b1; addr[15:0] = 16'h0044;
    step();
    chk("fresh_type", longint'(a_ev_type[2:0]), 0);
    chk("fresh_valid", longint'(a_ev_valid[0]), 1);
    idle();

    // two channels in parallel
    do_reset();
    rd[0] = 1'b1; addr[15:0] = 16'h0080;
    wr[1] = 1'b1; st[1] = 1'b1; addr[31:16] = 16'h1234;
    step();
    chk("mc_valid0", longint'(a_ev_valid), 1);
    step();
    chk("mc_valid1", longint'(a_ev_valid), 1);
    st[1] = 1'b0;
    step();
    chk("mc_valid2", longint'(a_ev_valid), 3);
    chk("mc_type1", longint'(a_ev_type[5:3]), 3);
    chk("mc_lat1", longint'(a_ev_lat[15:8]), 2);
    chk("mc_addr1", longint'(a_ev_addr[31:16]), 32'h1234);
    idle();
    read_cnt(1, 3, 1, 0, "mc_ch1_cnt3");
    read_cnt(0, 0, 3, 3, "mc_ch0_cnt0");

    // randomized traffic
    run[0] = 0; run[1] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int c = 0; c < 2; c++) begin
        rd[c] = ($urandom_range(99) < 35);
        wr[c] = ($urandom_range(99) < 30);
        ci[c] = ($urandom_range(99) < 85);
        dt[c] = $urandom_range(1);
        if (run[c] > 0) begin
          st[c] = 1'b1;
          run[c]--;
        end else if ($urandom_range(99) < 20) begin
          st[c] = 1'b1;
          run[c] = $urandom_range(12);
        end else begin
          st[c] = 1'b0;
        end
      end
      addr   = $urandom;
      en     = ($urandom_range(99) < 92);
      clr    = ($urandom_range(99) < 2);
      rst_n  = ($urandom_range(999) >= 5);
      rd_ch  = $urandom_range(1);
      rd_idx = 3'($urandom_range(7));
      step();
    end
    rst_n = 1'b1;
    idle();
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
